// File: rtl/pong_game_core.sv
// Pong game-state engine (paddles, ball, scores, serve/play/over FSM) with scan-position pixel decode; PONG_SPEEDUP_EN adds per-hit |dx| growth.
// Latency: state/position/score update 1 cycle after a frame_tick edge; pixel flags are combinational on x,y.
// Backpressure: none; frame_tick gates every update, point_pulse self-clears after one cycle.
module pong_game_core #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BORDER       = 5,
    parameter int PAD_W        = 4,
    parameter int PAD_H        = 90,
    parameter int PAD1_X       = 40,
    parameter int PAD2_X       = 600,
    parameter int PAD_VEL      = 2,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_VEL     = 2,
    parameter int BALL_VEL_MAX = 6,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               up1,
    input  logic               down1,
    input  logic               up2,
    input  logic               down2,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic               pad1_on,
    output logic               pad2_on,
    output logic               ball_on,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [2:0]         state,
    output logic               game_over,
    output logic               point_pulse
);
    typedef logic signed [10:0] s11_t;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam s11_t L_BORDER = s11_t'(BORDER);
    localparam s11_t L_PMAX   = s11_t'(V_ACTIVE - BORDER - PAD_H);
    localparam s11_t L_PVEL   = s11_t'(PAD_VEL);
    localparam s11_t L_PH1    = s11_t'(PAD_H - 1);
    localparam s11_t L_P1X    = s11_t'(PAD1_X);
    localparam s11_t L_P1XR   = s11_t'(PAD1_X + PAD_W - 1);
    localparam s11_t L_P1HIT  = s11_t'(PAD1_X + PAD_W);
    localparam s11_t L_P2X    = s11_t'(PAD2_X);
    localparam s11_t L_P2XR   = s11_t'(PAD2_X + PAD_W - 1);
    localparam s11_t L_P2HIT  = s11_t'(PAD2_X - BALL_SIZE);
    localparam s11_t L_BSZ    = s11_t'(BALL_SIZE);
    localparam s11_t L_BSZ1   = s11_t'(BALL_SIZE - 1);
    localparam s11_t L_VBOT   = s11_t'(V_ACTIVE - BORDER);
    localparam s11_t L_YBOT   = s11_t'(V_ACTIVE - BORDER - BALL_SIZE);
    localparam s11_t L_HRIGHT = s11_t'(H_ACTIVE - BORDER);
    localparam s11_t L_HACT   = s11_t'(H_ACTIVE);
    localparam s11_t L_VACT   = s11_t'(V_ACTIVE);
    localparam s11_t L_VEL    = s11_t'(BALL_VEL);
`ifdef PONG_SPEEDUP_EN
    localparam s11_t L_VMAX   = s11_t'(BALL_VEL_MAX);
`endif
    localparam logic [9:0] C_BX = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] C_BY = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] C_PY = 10'((V_ACTIVE - PAD_H) / 2);
    localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] S_WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] S_MAX  = {SCORE_W{1'b1}};

    state_t             state_q, state_d;
    logic [9:0]         pad1_y_q, pad1_y_d, pad2_y_q, pad2_y_d;
    logic [9:0]         ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    s11_t               ball_dx_q, ball_dx_d, ball_dy_q, ball_dy_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [CNT_W-1:0]   serve_cnt_q, serve_cnt_d;
    logic               serve_right_q, serve_right_d;
    logic               game_over_q, game_over_d;
    logic               point_pulse_q, point_pulse_d;

    s11_t bx, by, p1y, p2y, nx, ny, dx_mag, dy_mag, hit_mag, vy_res, vdy;
    logic hit1, hit2, miss_l, miss_r, go_serve, clr_scores;

    assign bx  = $signed({1'b0, ball_x_q});
    assign by  = $signed({1'b0, ball_y_q});
    assign p1y = $signed({1'b0, pad1_y_q});
    assign p2y = $signed({1'b0, pad2_y_q});

    function automatic logic [9:0] pad_step(input logic [9:0] py, input logic up, input logic dn);
        s11_t p;
        p = $signed({1'b0, py});
        if (up && !dn) p = p - L_PVEL;
        else if (dn && !up) p = p + L_PVEL;
        if (p < L_BORDER) p = L_BORDER;
        else if (p > L_PMAX) p = L_PMAX;
        return p[9:0];
    endfunction

    always_comb begin
        nx     = bx + ball_dx_q;
        ny     = by + ball_dy_q;
        dx_mag = ball_dx_q[10] ? -ball_dx_q : ball_dx_q;
        dy_mag = ball_dy_q[10] ? -ball_dy_q : ball_dy_q;
`ifdef PONG_SPEEDUP_EN
        hit_mag = (dx_mag >= L_VMAX) ? L_VMAX : dx_mag + s11_t'(1);
`else
        hit_mag = dx_mag;
`endif
        vy_res = ny;
        vdy    = ball_dy_q;
        if (ny <= L_BORDER) begin
            vy_res = L_BORDER;
            vdy    = dy_mag;
        end else if (ny + L_BSZ >= L_VBOT) begin
            vy_res = L_YBOT;
            vdy    = -dy_mag;
        end
        // Crossing tests use the pre-move position so a fast ball cannot tunnel through a paddle face.
        hit1   = ball_dx_q[10] && (bx >= L_P1HIT) && (nx <= L_P1XR)
                 && (by <= p1y + L_PH1) && (by + L_BSZ1 >= p1y);
        hit2   = !ball_dx_q[10] && (ball_dx_q != '0) && (bx + L_BSZ <= L_P2X) && (nx + L_BSZ1 >= L_P2X)
                 && (by <= p2y + L_PH1) && (by + L_BSZ1 >= p2y);
        miss_l = (nx <= L_BORDER);
        miss_r = (nx + L_BSZ >= L_HRIGHT);

        state_d       = state_q;
        pad1_y_d      = pad1_y_q;
        pad2_y_d      = pad2_y_q;
        ball_x_d      = ball_x_q;
        ball_y_d      = ball_y_q;
        ball_dx_d     = ball_dx_q;
        ball_dy_d     = ball_dy_q;
        score1_d      = score1_q;
        score2_d      = score2_q;
        serve_cnt_d   = serve_cnt_q;
        serve_right_d = serve_right_q;
        point_pulse_d = 1'b0;
        go_serve      = 1'b0;
        clr_scores    = 1'b0;

        if (frame_tick) begin
            if (state_q == ST_SERVE || state_q == ST_PLAY) begin
                pad1_y_d = pad_step(pad1_y_q, up1, down1);
                pad2_y_d = pad_step(pad2_y_q, up2, down2);
            end
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    go_serve   = start;
                    clr_scores = start;
                end
                ST_SERVE: begin
                    if (serve_cnt_q == CNT_LAST) begin
                        state_d     = ST_PLAY;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + CNT_W'(1);
                    end
                end
                ST_PLAY: begin
                    if (hit1 || hit2) begin
                        ball_x_d  = hit1 ? L_P1HIT[9:0] : L_P2HIT[9:0];
                        ball_dx_d = hit1 ? hit_mag : -hit_mag;
                        ball_y_d  = vy_res[9:0];
                        ball_dy_d = vdy;
                    end else if (miss_l || miss_r) begin
                        state_d       = ST_POINT;
                        point_pulse_d = 1'b1;
                        serve_right_d = !miss_l;
                        if (miss_l) score2_d = (score2_q == S_MAX) ? score2_q : score2_q + SCORE_W'(1);
                        else        score1_d = (score1_q == S_MAX) ? score1_q : score1_q + SCORE_W'(1);
                    end else begin
                        ball_x_d  = nx[9:0];
                        ball_y_d  = vy_res[9:0];
                        ball_dy_d = vdy;
                    end
                end
                ST_POINT: begin
                    if (score1_q == S_WIN || score2_q == S_WIN) state_d = ST_OVER;
                    else go_serve = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
            // Every SERVE entry recentres and rearms the ball toward the last loser.
            if (go_serve) begin
                state_d     = ST_SERVE;
                ball_x_d    = C_BX;
                ball_y_d    = C_BY;
                ball_dx_d   = serve_right_q ? L_VEL : -L_VEL;
                ball_dy_d   = L_VEL;
                serve_cnt_d = '0;
            end
            if (clr_scores) begin
                score1_d = '0;
                score2_d = '0;
            end
        end
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pad1_y_q      <= C_PY;
            pad2_y_q      <= C_PY;
            ball_x_q      <= C_BX;
            ball_y_q      <= C_BY;
            ball_dx_q     <= L_VEL;
            ball_dy_q     <= L_VEL;
            score1_q      <= '0;
            score2_q      <= '0;
            serve_cnt_q   <= '0;
            serve_right_q <= 1'b1;
            game_over_q   <= 1'b0;
            point_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pad1_y_q      <= pad1_y_d;
            pad2_y_q      <= pad2_y_d;
            ball_x_q      <= ball_x_d;
            ball_y_q      <= ball_y_d;
            ball_dx_q     <= ball_dx_d;
            ball_dy_q     <= ball_dy_d;
            score1_q      <= score1_d;
            score2_q      <= score2_d;
            serve_cnt_q   <= serve_cnt_d;
            serve_right_q <= serve_right_d;
            game_over_q   <= game_over_d;
            point_pulse_q <= point_pulse_d;
        end
    end

    s11_t xs, ys;
    logic vis;
    assign xs  = $signed({1'b0, x});
    assign ys  = $signed({1'b0, y});
    assign vis = (xs < L_HACT) && (ys < L_VACT);

    assign pad1_on = vis && (xs >= L_P1X) && (xs <= L_P1XR) && (ys >= p1y) && (ys <= p1y + L_PH1);
    assign pad2_on = vis && (xs >= L_P2X) && (xs <= L_P2XR) && (ys >= p2y) && (ys <= p2y + L_PH1);
    assign ball_on = vis && (xs >= bx) && (xs <= bx + L_BSZ1) && (ys >= by) && (ys <= by + L_BSZ1);

    assign score1      = score1_q;
    assign score2      = score2_q;
    assign state       = state_q;
    assign game_over   = game_over_q;
    assign point_pulse = point_pulse_q;
endmodule

// File: tb/tb_pong_game_core.sv
// Directed bench for pong_game_core (WIN_SCORE=2): reset, serve timing, paddle clamps, bounces, paddle hits, misses, game over, mid-game reset.
module tb_pong_game_core;
    logic       clk = 1'b0;
    logic       reset, frame_tick, start, up1, down1, up2, down2;
    logic [9:0] x, y;
    logic       pad1_on, pad2_on, ball_on, game_over, point_pulse;
    logic [3:0] score1, score2;
    logic [2:0] state;

    int n_vec = 0;
    int n_miscmp = 0;

    pong_game_core #(.WIN_SCORE(2)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
        .up1(up1), .down1(down1), .up2(up2), .down2(down2),
        .x(x), .y(y),
        .pad1_on(pad1_on), .pad2_on(pad2_on), .ball_on(ball_on),
        .score1(score1), .score2(score2), .state(state),
        .game_over(game_over), .point_pulse(point_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ball(input string tag, input int ex, input int ey);
        chk({tag, "_bx"}, int'(dut.ball_x_q), ex);
        chk({tag, "_by"}, int'(dut.ball_y_q), ey);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pix(input string tag, input int px, input int py, input int e1, input int e2, input int eb);
        x = 10'(px);
        y = 10'(py);
        #1;
        chk({tag, "_p1"}, int'(pad1_on), e1);
        chk({tag, "_p2"}, int'(pad2_on), e2);
        chk({tag, "_bl"}, int'(ball_on), eb);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; frame_tick = 1'b1; start = 1'b0;
        up1 = 1'b0; down1 = 1'b0; up2 = 1'b0; down2 = 1'b0;
        x = '0; y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", int'(state), 0);
        chk("rst_pad1", int'(dut.pad1_y_q), 195);
        chk("rst_pad2", int'(dut.pad2_y_q), 195);
        chk_ball("rst", 316, 236);
        chk("rst_dx", int'($signed(dut.ball_dx_q)), 2);
        chk("rst_dy", int'($signed(dut.ball_dy_q)), 2);
        chk("rst_s1", int'(score1), 0);
        chk("rst_s2", int'(score2), 0);
        chk("rst_pp", int'(point_pulse), 0);
        chk("rst_go", int'(game_over), 0);
        reset = 1'b1; frame_tick = 1'b0;

        pix("pix_a", 40, 195, 1, 0, 0);
        pix("pix_b", 44, 195, 0, 0, 0);
        pix("pix_c", 43, 284, 1, 0, 0);
        pix("pix_d", 43, 285, 0, 0, 0);
        pix("pix_e", 603, 200, 0, 1, 0);
        pix("pix_f", 323, 243, 0, 0, 1);
        pix("pix_g", 324, 243, 0, 0, 0);
        pix("pix_h", 316, 244, 0, 0, 0);

        tick();
        chk("idle_hold", int'(state), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("serve_enter", int'(state), 1);
        ticks(59);
        chk("serve_59", int'(state), 1);
        chk_ball("serve_hold", 316, 236);
        tick();
        chk("play_enter", int'(state), 2);
        tick();
        chk_ball("p1", 318, 238);
        pix("pix_i", 325, 245, 0, 0, 1);
        pix("pix_j", 317, 245, 0, 0, 0);

        // rally 1: left paddle up to its clamp, right paddle parked at 195
        up1 = 1'b1;
        ticks(94);
        chk("pad1_p95", int'(dut.pad1_y_q), 7);
        tick();
        chk("pad1_clamp", int'(dut.pad1_y_q), 5);
        ticks(20);
        chk_ball("bounce_bot", 548, 467);
        chk("bounce_dy", int'($signed(dut.ball_dy_q)), -2);
        ticks(9);
        chk("pad1_nowrap", int'(dut.pad1_y_q), 5);
        down1 = 1'b1;
        ticks(10);
        chk("pad1_both", int'(dut.pad1_y_q), 5);
        up1 = 1'b0; down1 = 1'b0;
        ticks(20);
        chk("p155_state", int'(state), 2);
        chk_ball("p155", 626, 389);
        tick();
        chk("miss1_state", int'(state), 3);
        chk("miss1_s1", int'(score1), 1);
        chk("miss1_s2", int'(score2), 0);
        chk("miss1_pp", int'(point_pulse), 1);
        chk_ball("miss1_frz", 626, 389);
        @(posedge clk);
        #1;
        chk("miss1_pp_clr", int'(point_pulse), 0);
        chk("miss1_hold", int'(state), 3);
        tick();
        chk("serve2_state", int'(state), 1);
        chk_ball("serve2", 316, 236);
        chk("serve2_dx", int'($signed(dut.ball_dx_q)), 2);
        chk("serve2_s1", int'(score1), 1);

        // rally 2: right paddle to bottom clamp, left paddle to 65
        down1 = 1'b1; down2 = 1'b1;
        ticks(30);
        chk("pad1_65", int'(dut.pad1_y_q), 65);
        down1 = 1'b0;
        ticks(30);
        chk("play2_enter", int'(state), 2);
        chk("pad2_315", int'(dut.pad2_y_q), 315);
        ticks(120);
        chk("pad2_clamp", int'(dut.pad2_y_q), 385);
        ticks(19);
        chk_ball("hit_r", 592, 421);
        chk("hit_r_dx", int'($signed(dut.ball_dx_q)), -2);
        ticks(208);
        chk_ball("bounce_top", 176, 5);
        chk("bounce_top_dy", int'($signed(dut.ball_dy_q)), 2);
        ticks(66);
        chk_ball("pre_hit_l", 44, 137);
        tick();
        chk_ball("hit_l", 44, 139);
`ifdef PONG_SPEEDUP_EN
        chk("hit_l_dx", int'($signed(dut.ball_dx_q)), 3);
`else
        chk("hit_l_dx", int'($signed(dut.ball_dx_q)), 2);
`endif
        ticks(291);
        chk("p705_state", int'(state), 2);
        chk_ball("p705", 626, 213);
        tick();
        chk("miss2_state", int'(state), 3);
        chk("miss2_s1", int'(score1), 2);
        chk("miss2_pp", int'(point_pulse), 1);
        tick();
        chk("over_state", int'(state), 4);
        chk("over_go", int'(game_over), 1);
        down2 = 1'b0; up2 = 1'b1;
        ticks(10);
        chk("over_hold", int'(state), 4);
        chk_ball("over_frz", 626, 213);
        chk("over_pad2", int'(dut.pad2_y_q), 385);
        chk("over_s1", int'(score1), 2);
        up2 = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_state", int'(state), 1);
        chk("restart_s1", int'(score1), 0);
        chk("restart_s2", int'(score2), 0);
        chk("restart_go", int'(game_over), 0);
        chk_ball("restart", 316, 236);
        down1 = 1'b1;
        ticks(5);
        chk("pad1_75", int'(dut.pad1_y_q), 75);
        down1 = 1'b0;

        // mid-game reset wins over a coincident frame_tick
        reset = 1'b0; frame_tick = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1; frame_tick = 1'b0;
        chk("mrst_state", int'(state), 0);
        chk("mrst_pad1", int'(dut.pad1_y_q), 195);
        chk("mrst_pad2", int'(dut.pad2_y_q), 195);
        chk_ball("mrst", 316, 236);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
